// File: rtl/audio_i2s_serializer.sv
// Stereo DAC serializer: a {L,R} frame FIFO feeding a BCK/LRCK/SDATA generator.
// Left-justified or I2S, MSB first, with data padded to the slot width.
module audio_i2s_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SLOT_WIDTH = 16,
  parameter int unsigned BCK_DIV    = 6,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                iCLK,
  input  logic                                iRST,
  input  logic                                iENABLE,
  input  logic                                iI2S_MODE,
  input  logic [DATA_WIDTH-1:0]               iSAMPLE_L,
  input  logic [DATA_WIDTH-1:0]               iSAMPLE_R,
  input  logic                                iVALID,
  output logic                                oREADY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     oFIFO_LEVEL,
  output logic                                oUNDERRUN,
  output logic                                oAUD_BCK,
  output logic                                oAUD_LRCK,
  output logic                                oAUD_DATA
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(2 * SLOT_WIDTH);
  localparam int unsigned CW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int unsigned FW = 2 * DATA_WIDTH;

  localparam logic [CW-1:0] DivLast  = CW'(BCK_DIV - 1);
  localparam logic [BW-1:0] BitcLast = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] SlotW    = BW'(SLOT_WIDTH);
  localparam logic [LW-1:0] DepthL   = LW'(FIFO_DEPTH);

  // FIFO storage and pointers (one extra wrap bit so level = wr - rd)
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [LW-1:0] wr_ptr_q, rd_ptr_q, level;
  logic          full, empty, push, pop, rst_q;

  // Serial engine state
  logic [CW-1:0] div_q;
  logic [BW-1:0] bitc_q;
  logic          bck_q, lrck_q, data_q, underrun_q;
  logic [FW-1:0] shadow_q;
  logic          mode_q, started_q, loaded_q;

  // Next-bit datapath
  logic          fall_tick, mode_eff, load, right, bit_out;
  logic [BW-1:0] pos, offs;
  logic [FW-1:0] new_frame, frame;
  logic [DATA_WIDTH-1:0] sample, shifted;

  assign level  = wr_ptr_q - rd_ptr_q;
  assign full   = (level == DepthL);
  assign empty  = (level == '0);
  assign oREADY = !full && !rst_q;
  assign push   = iVALID && oREADY;

  assign oFIFO_LEVEL = level;
  assign oUNDERRUN   = underrun_q;
  assign oAUD_BCK    = bck_q;
  assign oAUD_LRCK   = lrck_q;
  assign oAUD_DATA   = data_q;

  always_comb begin
    fall_tick = iENABLE && (div_q == DivLast) && bck_q;
    // Before the first frame load the live mode pin decides where the frame starts.
    mode_eff  = started_q ? mode_q : iI2S_MODE;
    if (mode_eff) begin
      pos = (bitc_q == '0) ? BitcLast : bitc_q - BW'(1);
    end else begin
      pos = bitc_q;
    end
    // loaded_q blocks a second pop when a mode switch moves the frame start by one bit.
    load      = (pos == '0) && !loaded_q;
    pop       = fall_tick && load && !empty;
    new_frame = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    frame     = load ? new_frame : shadow_q;
    right     = (pos >= SlotW);
    offs      = right ? pos - SlotW : pos;
    sample    = right ? frame[DATA_WIDTH-1:0] : frame[FW-1:DATA_WIDTH];
    // Offsets past the sample width shift everything out, giving the zero pad.
    shifted   = sample << offs;
    bit_out   = shifted[DATA_WIDTH-1];
  end

  always_ff @(posedge iCLK) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {iSAMPLE_L, iSAMPLE_R};
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rst_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      div_q      <= '0;
      bitc_q     <= '0;
      bck_q      <= 1'b0;
      lrck_q     <= 1'b0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
      shadow_q   <= '0;
      mode_q     <= 1'b0;
      started_q  <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      rst_q      <= 1'b0;
      underrun_q <= fall_tick && load && empty;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + LW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + LW'(1);
      end
      if (!iENABLE) begin
        div_q     <= '0;
        bitc_q    <= '0;
        bck_q     <= 1'b0;
        lrck_q    <= 1'b0;
        data_q    <= 1'b0;
        shadow_q  <= '0;
        started_q <= 1'b0;
        loaded_q  <= 1'b0;
      end else begin
        if (div_q == DivLast) begin
          div_q <= '0;
          bck_q <= !bck_q;
        end else begin
          div_q <= div_q + CW'(1);
        end
        if (fall_tick) begin
          lrck_q <= (bitc_q >= SlotW);
          data_q <= bit_out;
          bitc_q <= (bitc_q == BitcLast) ? '0 : bitc_q + BW'(1);
          if (load) begin
            shadow_q  <= new_frame;
            mode_q    <= iI2S_MODE;
            started_q <= 1'b1;
            loaded_q  <= 1'b1;
          end else if (bitc_q == BitcLast) begin
            loaded_q <= 1'b0;
          end
        end
      end
    end
  end

endmodule
